// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: sequential unsigned shift-and-add multiplier.
// One partial-product row per cycle: the multiplicand is AND-gated by the
// current multiplier bit and ripple-added into the upper half of the
// accumulator. The carry-extended sum is then shifted right with the lower half.
// After WIDTH iterations the accumulator holds a*b. That value is
// captured into product and flagged by a one-cycle done pulse.
module seq_shift_add_mult #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  load;
   logic [WIDTH-1:0]      mcand;
   logic [2*WIDTH-1:0]    acc;
   logic [2*WIDTH-1:0]    acc_shift;
   logic [WIDTH:0]        row_sum;
   logic [CNT_W-1:0]      cnt;
   logic                  last;

   // Partial-product row: multiplicand gated by a single multiplier bit.
   function automatic logic [WIDTH-1:0] pp_row(input logic [WIDTH-1:0] m,
                                               input logic             bit_sel);
      pp_row = m & {WIDTH{bit_sel}};
   endfunction

   // Row add keeping the carry-out as an extra MSB, so it survives the shift.
   function automatic logic [WIDTH:0] row_add(input logic [WIDTH-1:0] hi,
                                              input logic [WIDTH-1:0] pp);
      row_add = {1'b0, hi} + {1'b0, pp};
   endfunction

   // Combinational row add and right shift for the current iteration.
   always_comb begin
      row_sum   = row_add(acc[2*WIDTH-1:WIDTH], pp_row(mcand, acc[0]));
      acc_shift = {row_sum, acc[WIDTH-1:1]};
      last      = (cnt == CNT_W'(WIDTH - 1));
   end

   // Next-state logic; a start is accepted whenever the unit is not running,
   // which lets a new operation begin in the done cycle.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
               load      = 1'b1;
            end
         end
         S_RUN: begin
            if (last) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               state_nxt = S_RUN;
               load      = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand latch, accumulator iteration, iteration counter and result capture.
   // Reset also clears product so that an aborted operation leaves no result.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand   <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (load) begin
         mcand <= a;
         acc   <= {{WIDTH{1'b0}}, b};
         cnt   <= '0;
      end else if (state == S_RUN) begin
         acc <= acc_shift;
         cnt <= cnt + CNT_W'(1);
         if (last) begin
            product <= acc_shift;
         end
      end
   end

   // Status outputs decode directly from the state register.
   always_comb begin
      busy = (state == S_RUN);
      done = (state == S_DONE);
   end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: scoreboard bench for seq_shift_add_mult (WIDTH=4).
// Expected products are queued when a start is accepted and compared on done.
module tb_seq_shift_add_mult;

   localparam int WIDTH = 4;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   int n_checks = 0;
   int n_pass   = 0;
   logic [2*WIDTH-1:0] exp_q[$];

   seq_shift_add_mult #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Compare the product on every done pulse against the oldest expected value.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
         end else begin
            check("product", 32'(product), 32'(exp_q.pop_front()));
         end
      end
   end

   // Called at a negedge: drive start for one cycle; queue a result if accepted.
   task automatic go(input int av, input int bv);
      start = 1'b1;
      a     = WIDTH'(av);
      b     = WIDTH'(bv);
      if (busy === 1'b0) begin
         exp_q.push_back((2*WIDTH)'(av * bv));
      end
      @(negedge clk);
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
   endtask

   // Advance negedge by negedge until done is seen; stops on the done cycle.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      if (done !== 1'b1) begin
         check("done_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic run(input int av, input int bv);
      int cyc;
      go(av, bv);
      wait_done(cyc);
      @(negedge clk);
   endtask

   initial begin
      int cyc;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;

      // Reset then idle
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // Basic 13*11, with busy profile and latency
      go(13, 11);
      for (int i = 0; i < WIDTH; i++) begin
         check("basic_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      check("basic_done", 32'(done), 32'd1);
      check("basic_busy_end", 32'(busy), 32'd0);
      check("basic_value", 32'(product), 32'd143);
      @(negedge clk);
      check("basic_done_pulse", 32'(done), 32'd0);

      // Carry stress and zero/one operands
      run(15, 15);
      check("carry_value", 32'(product), 32'd225);
      run(0, 9);
      run(9, 0);
      run(1, 15);
      check("one_value", 32'(product), 32'd15);

      // Start while busy is ignored
      go(3, 5);
      go(7, 7);
      wait_done(cyc);
      check("busy_ignore_value", 32'(product), 32'd15);
      repeat (8) @(negedge clk);
      check("busy_ignore_idle", 32'(busy), 32'd0);

      // Back-to-back
      go(6, 7);
      wait_done(cyc);
      check("b2b_first", 32'(product), 32'd42);
      go(12, 12);
      for (int i = 0; i < WIDTH; i++) begin
         check("b2b_hold", 32'(product), 32'd42);
         @(negedge clk);
      end
      wait_done(cyc);
      check("b2b_latency", 32'(cyc), 32'd0);
      check("b2b_second", 32'(product), 32'd144);
      @(negedge clk);

      // Reset mid-operation
      go(10, 10);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_product", 32'(product), 32'd0);
      repeat (8) @(negedge clk);
      check("abort_product_hold", 32'(product), 32'd0);
      run(2, 3);
      check("after_abort_value", 32'(product), 32'd6);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute guard so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
